// File: rtl/note_scheduler.sv
// note_scheduler: walks the note chart ROM in order and issues each note once its timestamp
// falls inside the lookahead window. Define NOTE_SCHED_LATE_DROP_EN to skip notes already too late.
module note_scheduler #(
  parameter int TIME_W    = 32,
  parameter int ADDR_W    = 12,
  parameter int LANES     = 5,
  parameter int LOOKAHEAD = 2000,
  parameter int LATE_WIN  = 150
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    game_reset,
  input  logic                    pause,
  input  logic [TIME_W-1:0]       song_time,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [TIME_W+LANES-1:0] rom_data,
  output logic                    note_valid,
  input  logic                    note_ready,
  output logic [TIME_W-1:0]       note_time,
  output logic [LANES-1:0]        note_lanes,
  output logic                    chart_done,
  output logic [15:0]             notes_issued,
  output logic [15:0]             notes_dropped
);

`ifdef NOTE_SCHED_LATE_DROP_EN
  localparam logic LATE_DROP_EN = 1'b1;
`else
  localparam logic LATE_DROP_EN = 1'b0;
`endif

  localparam logic [TIME_W:0] LOOKAHEAD_EXT = (TIME_W+1)'(LOOKAHEAD);
  localparam logic [TIME_W:0] LATE_WIN_EXT  = (TIME_W+1)'(LATE_WIN);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_CHECK   = 3'd3,
    S_PRESENT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [TIME_W-1:0]   last_q;
  logic [TIME_W-1:0]   time_q, time_d;
  logic [LANES-1:0]    lanes_q, lanes_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic [15:0]         issued_q, issued_d;
  logic [15:0]         dropped_q, dropped_d;
  logic                rewind_s, due_s, late_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A backwards step of song_time means the timer restarted underneath us.
  assign rewind_s = game_reset || (song_time < last_q);
  assign due_s    = ({1'b0, time_q} <= ({1'b0, song_time} + LOOKAHEAD_EXT));
  assign late_s   = LATE_DROP_EN && (({1'b0, time_q} + LATE_WIN_EXT) < {1'b0, song_time});

  // Next-state, chart address, latched note and counter computation.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    time_d    = time_q;
    lanes_d   = lanes_q;
    issued_d  = issued_q;
    dropped_d = dropped_q;
    if (rewind_s) begin
      state_d   = S_IDLE;
      addr_d    = '0;
      issued_d  = 16'd0;
      dropped_d = 16'd0;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_FETCH;
        S_FETCH: state_d = S_WAIT;
        S_WAIT: begin
          time_d  = rom_data[TIME_W+LANES-1:LANES];
          lanes_d = rom_data[LANES-1:0];
          state_d = S_CHECK;
        end
        S_CHECK: begin
          if (lanes_q == '0) begin
            state_d = S_DONE;
          end else if (late_s) begin
            dropped_d = sat_inc(dropped_q);
            if (&addr_q) begin
              state_d = S_DONE;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = S_FETCH;
            end
          end else if (!pause && due_s) begin
            state_d = S_PRESENT;
          end else begin
            state_d = S_CHECK;
          end
        end
        S_PRESENT: begin
          if (note_ready) begin
            issued_d = sat_inc(issued_q);
            if (&addr_q) begin
              state_d = S_DONE;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = S_FETCH;
            end
          end else begin
            state_d = S_PRESENT;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
    valid_d = (state_d == S_PRESENT);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      last_q    <= '0;
      time_q    <= '0;
      lanes_q   <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      issued_q  <= 16'd0;
      dropped_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      last_q    <= song_time;
      time_q    <= time_d;
      lanes_q   <= lanes_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      issued_q  <= issued_d;
      dropped_q <= dropped_d;
    end
  end

  assign rom_addr      = addr_q;
  assign note_valid    = valid_q;
  assign note_time     = time_q;
  assign note_lanes    = lanes_q;
  assign chart_done    = done_q;
  assign notes_issued  = issued_q;
  assign notes_dropped = dropped_q;

endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: randomized chart/handshake stimulus with a queue scoreboard fed by a
// sequence-level chart model; a negedge monitor checks every accepted note and hold behaviour.
module tb_note_scheduler;
  localparam int TW = 32;
  localparam int AW = 12;
  localparam int LN = 5;
  localparam int DEPTH = 4096;
`ifdef NOTE_SCHED_LATE_DROP_EN
  localparam bit LATE_EN = 1'b1;
`else
  localparam bit LATE_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n, game_reset, pause, note_ready;
  logic [TW-1:0]    song_time;
  logic [AW-1:0]    rom_addr;
  logic [TW+LN-1:0] rom_data = '0;
  logic             note_valid, chart_done;
  logic [TW-1:0]    note_time;
  logic [LN-1:0]    note_lanes;
  logic [15:0]      notes_issued, notes_dropped;

  always #5 clk = ~clk;

  note_scheduler dut (
    .clk(clk), .reset_n(reset_n), .game_reset(game_reset), .pause(pause),
    .song_time(song_time), .rom_addr(rom_addr), .rom_data(rom_data),
    .note_valid(note_valid), .note_ready(note_ready), .note_time(note_time),
    .note_lanes(note_lanes), .chart_done(chart_done), .notes_issued(notes_issued),
    .notes_dropped(notes_dropped)
  );

  logic [TW+LN-1:0] mem [DEPTH];
  always @(posedge clk) rom_data <= mem[rom_addr];

  logic [TW+LN-1:0] sb [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: walks the chart as a list for a fixed song time.
  int m_idx, m_issued, m_drops;
  bit m_done;

  task automatic model_reset();
    m_idx = 0; m_issued = 0; m_drops = 0; m_done = 1'b0;
  endtask

  task automatic model_step();
    if (m_idx == DEPTH-1) m_done = 1'b1;
    else m_idx++;
  endtask

  task automatic model_run(input logic [TW-1:0] st);
    logic [TW+LN-1:0] e;
    logic [TW:0] ts;
    bit stop;
    stop = 1'b0;
    while (!m_done && !stop) begin
      e  = mem[m_idx];
      ts = {1'b0, e[TW+LN-1:LN]};
      if (e[LN-1:0] == '0) m_done = 1'b1;
      else if (LATE_EN && (ts + 33'd150 < {1'b0, st})) begin m_drops++; model_step(); end
      else if (ts <= {1'b0, st} + 33'd2000) begin sb.push_back(e); m_issued++; model_step(); end
      else stop = 1'b1;
    end
  endtask

  // Monitor: scoreboard pop on handshake, hold stability, pause gating and due-time rules.
  logic          prev_valid = 1'b0, prev_pause = 1'b0, hold_pend = 1'b0, rew;
  logic [TW-1:0] prev_st = '0, held_t = '0;
  logic [LN-1:0] held_l = '0;
  logic [TW+LN-1:0] exp_e;
  int acc = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete(); acc = 0; hold_pend = 1'b0; prev_valid = 1'b0; prev_pause = 1'b0; prev_st = '0;
    end else begin
      rew = game_reset || (song_time < prev_st);
      chk("issued_count", notes_issued, acc);
      if (hold_pend) chk("hold_stable", {note_valid, note_time, note_lanes}, {1'b1, held_t, held_l});
      if (note_valid && !prev_valid) begin
        chk("pause_gate", prev_pause, 1'b0);
        chk("due_window", ({1'b0, note_time} <= {1'b0, prev_st} + 33'd2000), 1'b1);
      end
      if (rew) begin
        sb.delete(); acc = 0; hold_pend = 1'b0;
      end else begin
        if (note_valid && note_ready) begin
          if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_note: got %0d/%0h expected none", note_time, note_lanes);
          end else begin
            exp_e = sb.pop_front();
            chk("note", {note_time, note_lanes}, exp_e);
          end
          acc++;
        end
        hold_pend = note_valid && !note_ready;
        held_t = note_time; held_l = note_lanes;
      end
      prev_valid = note_valid; prev_pause = pause; prev_st = song_time;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rnd_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      note_ready = 1'($urandom_range(0, 1));
      pause = ($urandom_range(0, 3) == 0);
    end
    pause = 1'b0;
  endtask

  task automatic do_rewind(input logic [TW-1:0] st);
    @(posedge clk); #1;
    game_reset = 1'b1; song_time = st; note_ready = 1'b0; pause = 1'b0;
    @(posedge clk); #1;
    game_reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_valid(input int max, input string name);
    int k;
    k = 0;
    while (!note_valid && k < max) begin cycles(1); k++; end
    chk(name, note_valid, 1'b1);
  endtask

  task automatic check_stage(input string name);
    chk({name, "_issued"}, notes_issued, m_issued);
    chk({name, "_dropped"}, notes_dropped, m_drops);
    chk({name, "_done"}, chart_done, m_done);
    chk({name, "_addr"}, rom_addr, m_idx);
    chk({name, "_valid"}, note_valid, 1'b0);
    chk({name, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic check_zero(input string name);
    chk(name, {note_valid, rom_addr, chart_done, notes_issued, notes_dropped, note_time, note_lanes}, '0);
  endtask

  task automatic load_basic();
    mem[0] = {32'd1000, 5'b00001};
    mem[1] = {32'd3000, 5'b00110};
    mem[2] = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    logic [TW-1:0] st1, st2;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    reset_n = 1'b0; game_reset = 1'b0; pause = 1'b0; note_ready = 1'b0; song_time = '0;
    model_reset();
    cycles(3);
    check_zero("reset_outputs");
    @(negedge clk); reset_n = 1'b1;

    // Basic chart with a song_time ramp.
    load_basic();
    do_rewind(32'd0);
    model_run(32'd1100);
    note_ready = 1'b1;
    for (int s = 0; s <= 1100; s++) begin song_time = s; cycles(1); end
    cycles(20);
    check_stage("ramp");

    // Backpressure: note held stable for 20 cycles.
    do_rewind(32'd0);
    model_run(32'd0);
    wait_valid(20, "hold_rise");
    cycles(20);
    chk("hold_time", note_time, 32'd1000);
    chk("hold_lanes", note_lanes, 5'b00001);
    chk("hold_count", notes_issued, 16'd0);
    note_ready = 1'b1; cycles(1); note_ready = 1'b0;
    cycles(10);
    check_stage("hold");

    // Pause blocks presentation; release presents within one cycle.
    do_rewind(32'd0);
    pause = 1'b1;
    model_run(32'd0);
    cycles(30);
    chk("pause_block", note_valid, 1'b0);
    pause = 1'b0; cycles(1);
    chk("unpause", note_valid, 1'b1);

    // Timer restart while a note is presented.
    song_time = 32'd5000; note_ready = 1'b1;
    model_run(32'd5000);
    k = 0;
    while (notes_issued == 16'd0 && k < 20) begin cycles(1); k++; end
    note_ready = 1'b0;
    chk("accept1", notes_issued, 16'd1);
    wait_valid(20, "present2");
    song_time = 32'd0; cycles(1);
    chk("trew_valid", note_valid, 1'b0);
    chk("trew_addr", rom_addr, 12'd0);
    chk("trew_issued", notes_issued, 16'd0);
    model_reset(); model_run(32'd0);
    note_ready = 1'b1; cycles(30);
    check_stage("rewound");

    // Asynchronous reset in WAIT.
    do_rewind(32'd0);
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1'b0; #1;
    check_zero("async_reset");
    @(negedge clk); @(negedge clk); reset_n = 1'b1;
    model_reset(); model_run(32'd0);
    note_ready = 1'b1; cycles(30);
    check_stage("post_reset");

`ifdef NOTE_SCHED_LATE_DROP_EN
    mem[0] = {32'd100, 5'b00001};
    mem[1] = {32'd5000, 5'b00010};
    mem[2] = '0;
    do_rewind(32'd400);
    model_run(32'd400);
    note_ready = 1'b1; cycles(30);
    check_stage("late_drop");
    song_time = 32'd3000; model_run(32'd3000); cycles(30);
    check_stage("late_after");
`endif

    // Random charts, two monotone song-time steps each.
    for (int r = 0; r < 16; r++) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) mem[i] = {32'($urandom_range(0, 12000)), 5'($urandom_range(1, 31))};
      mem[n] = '0;
      st1 = 32'($urandom_range(0, 6000));
      do_rewind(st1);
      model_run(st1);
      rnd_cycles(600);
      check_stage("rand_a");
      st2 = st1 + 32'($urandom_range(0, 8000));
      song_time = st2;
      model_run(st2);
      rnd_cycles(600);
      check_stage("rand_b");
    end

    // Full address space with no end marker.
    for (int i = 0; i < DEPTH; i++) mem[i] = {32'(i % 97), 5'((i % 31) + 1)};
    do_rewind(32'd0);
    model_run(32'd0);
    note_ready = 1'b1;
    cycles(4 * DEPTH + 50);
    check_stage("addr_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
